// File: rtl/tmds_channel_encoder.sv
// rtl/tmds_channel_encoder.sv - one DVI/TMDS 8b/10b channel encoder
//
// Purpose:
//   Encodes one 8-bit pixel component per PixelClk into a transition-minimised,
//   DC-balanced 10-bit TMDS character. During blanking (VideoDE=0) the Ctrl
//   pair is sent as one of the four control tokens. Two register stages:
//   stage 1 holds the transition-minimised word q_m, stage 2 holds the
//   DC-balanced output character and the running disparity.
//
// Optional build macro:
//   TMDS_VIDEO_GUARD_EN - adds two input delay stages (latency 4) and replaces
//   the up to two control characters directly preceding a DE rise with the
//   HDMI video guard-band character (CHANNEL 0/2: 10'h2CC, CHANNEL 1: 10'h133).
//   Undefined: latency 2, control slots carry Ctrl tokens only.
//
// Parameters:
//   CHANNEL   channel index 0..2, only selects the guard-band character
//
// Ports:
//   PixelClk  in   1   pixel clock, rising edge
//   RstB      in   1   asynchronous active-low reset
//   VideoDin  in   8   pixel component, meaningful when VideoDE=1
//   VideoDE   in   1   1 = video period, 0 = control period
//   Ctrl      in   2   {C1,C0} control pair used when VideoDE=0
//   TMDSDout  out  10  encoded character, bit 0 transmitted first

module tmds_channel_encoder #(
    parameter int CHANNEL = 0
) (
    input  logic       PixelClk,
    input  logic       RstB,
    input  logic [7:0] VideoDin,
    input  logic       VideoDE,
    input  logic [1:0] Ctrl,
    output logic [9:0] TMDSDout
);

    localparam logic [9:0] TOKEN_00   = 10'h354;
    localparam logic [9:0] TOKEN_01   = 10'h0AB;
    localparam logic [9:0] TOKEN_10   = 10'h154;
    localparam logic [9:0] TOKEN_11   = 10'h2AB;
    localparam logic [9:0] GUARD_CHAR = (CHANNEL == 1) ? 10'h133 : 10'h2CC;

    function automatic logic [3:0] f_popcount(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Transition-minimising stage: chained XOR or XNOR of the data bits,
    // with bit 8 recording which operator was used (1 = XOR).
    function automatic logic [8:0] f_qm(input logic [7:0] d);
        logic [3:0] n1d;
        logic       use_xnor;
        logic [8:0] q;
        n1d      = f_popcount(d);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        q        = 9'd0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] f_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = TOKEN_00;
            2'b01:   t = TOKEN_01;
            2'b10:   t = TOKEN_10;
            default: t = TOKEN_11;
        endcase
        return t;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1 input selection (optionally delayed by two cycles)
    // ------------------------------------------------------------------
    logic [7:0] w_s1_din;
    logic       w_s1_de;
    logic [1:0] w_s1_ctrl;
    logic       w_guard;

    logic [8:0] r_qm;
    logic       r_s1_de;
    logic [1:0] r_s1_ctrl;

`ifdef TMDS_VIDEO_GUARD_EN
    logic [7:0] r_d1_din;
    logic       r_d1_de;
    logic [1:0] r_d1_ctrl;
    logic [7:0] r_d2_din;
    logic       r_d2_de;
    logic [1:0] r_d2_ctrl;

    always_ff @(posedge PixelClk or negedge RstB) begin
        if (!RstB) begin
            r_d1_din  <= 8'd0;
            r_d1_de   <= 1'b0;
            r_d1_ctrl <= 2'b00;
            r_d2_din  <= 8'd0;
            r_d2_de   <= 1'b0;
            r_d2_ctrl <= 2'b00;
        end else begin
            r_d1_din  <= VideoDin;
            r_d1_de   <= VideoDE;
            r_d1_ctrl <= Ctrl;
            r_d2_din  <= r_d1_din;
            r_d2_de   <= r_d1_de;
            r_d2_ctrl <= r_d1_ctrl;
        end
    end

    assign w_s1_din  = r_d2_din;
    assign w_s1_de   = r_d2_de;
    assign w_s1_ctrl = r_d2_ctrl;

    // The slot being finalised in stage 2 is r_s1_*; r_d2_de and r_d1_de are
    // the DE of the next two output slots. A control slot becomes guard band
    // when a DE rise lands within the next two slots. If the slot right after
    // is already video, that is the rise itself; otherwise the one after that.
    assign w_guard = ~r_s1_de & (r_d2_de | r_d1_de);
`else
    assign w_s1_din  = VideoDin;
    assign w_s1_de   = VideoDE;
    assign w_s1_ctrl = Ctrl;
    assign w_guard   = 1'b0;
`endif

    logic [8:0] w_qm;
    assign w_qm = f_qm(w_s1_din);

    // ------------------------------------------------------------------
    // Stage 2: DC balancing against the running disparity
    // ------------------------------------------------------------------
    logic signed [4:0] r_cnt;
    logic        [9:0] r_dout;

    logic        [3:0] w_n1;
    logic signed [4:0] w_bal;      // N1 - N0 of q_m[7:0], range -8..8
    logic              w_q8;
    logic              w_cnt_pos;
    logic              w_cnt_neg;
    logic              w_bal_pos;
    logic              w_bal_neg;
    logic        [9:0] w_next_dout;
    logic signed [4:0] w_next_cnt;

    assign w_n1      = f_popcount(r_qm[7:0]);
    assign w_bal     = $signed({w_n1, 1'b0} - 5'd8);
    assign w_q8      = r_qm[8];
    assign w_cnt_neg = r_cnt[4];
    assign w_cnt_pos = !r_cnt[4] && (r_cnt != 5'sd0);
    assign w_bal_neg = w_bal[4];
    assign w_bal_pos = !w_bal[4] && (w_bal != 5'sd0);

    // Running disparity stays within the 5-bit signed range, so modulo-32
    // arithmetic in 5 bits yields the exact result.
    always_comb begin
        w_next_dout = TOKEN_00;
        w_next_cnt  = r_cnt;
        if (!r_s1_de) begin
            w_next_cnt  = 5'sd0;
            w_next_dout = w_guard ? GUARD_CHAR : f_token(r_s1_ctrl);
        end else if ((r_cnt == 5'sd0) || (w_bal == 5'sd0)) begin
            w_next_dout = {~w_q8, w_q8, (w_q8 ? r_qm[7:0] : ~r_qm[7:0])};
            w_next_cnt  = w_q8 ? (r_cnt + w_bal) : (r_cnt - w_bal);
        end else if ((w_cnt_pos && w_bal_pos) || (w_cnt_neg && w_bal_neg)) begin
            w_next_dout = {1'b1, w_q8, ~r_qm[7:0]};
            w_next_cnt  = r_cnt + (w_q8 ? 5'sd2 : 5'sd0) - w_bal;
        end else begin
            w_next_dout = {1'b0, w_q8, r_qm[7:0]};
            w_next_cnt  = r_cnt + w_bal - (w_q8 ? 5'sd0 : 5'sd2);
        end
    end

    always_ff @(posedge PixelClk or negedge RstB) begin
        if (!RstB) begin
            r_qm      <= 9'd0;
            r_s1_de   <= 1'b0;
            r_s1_ctrl <= 2'b00;
            r_cnt     <= 5'sd0;
            r_dout    <= TOKEN_00;
        end else begin
            r_qm      <= w_qm;
            r_s1_de   <= w_s1_de;
            r_s1_ctrl <= w_s1_ctrl;
            r_cnt     <= w_next_cnt;
            r_dout    <= w_next_dout;
        end
    end

    assign TMDSDout = r_dout;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// tb/tb_tmds_channel_encoder.sv - scoreboard bench for tmds_channel_encoder

module tb_tmds_channel_encoder;

`ifdef TMDS_VIDEO_GUARD_EN
    localparam int GL  = 2;
    localparam int LAT = 4;
    localparam bit GEN = 1'b1;
`else
    localparam int GL  = 0;
    localparam int LAT = 2;
    localparam bit GEN = 1'b0;
`endif
    localparam logic [9:0] GCH = 10'h133;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'd0;
    logic       de = 1'b0;
    logic [1:0] ctrl = 2'b00;
    logic [9:0] dout;

    tmds_channel_encoder #(.CHANNEL(1)) dut (
        .PixelClk (clk),
        .RstB     (rst_n),
        .VideoDin (din),
        .VideoDE  (de),
        .Ctrl     (ctrl),
        .TMDSDout (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] din;
        bit         hk;
        logic [9:0] kv;
    } slot_t;

    typedef struct {
        logic [9:0] exp;
        bit         video;
        logic [7:0] din;
        bit         hk;
        logic [9:0] kv;
    } exp_t;

    slot_t slot_q[$];
    exp_t  exp_q[$];
    int    m_cnt;
    int    total = 0;
    int    bad = 0;
    bit    active = 1'b1;
    exp_t  mon_e;

    function automatic logic [9:0] ctrl_tok(input logic [1:0] c);
        case (c)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    // DVI 1.0 encoding rules, written with integer arithmetic.
    function automatic logic [9:0] model_video(input logic [7:0] d);
        int         n1d;
        bit         inv;
        logic [7:0] q;
        bit         q8;
        int         bal;
        logic [9:0] o;
        n1d = $countones(d);
        inv = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = inv ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q8  = !inv;
        bal = 2 * $countones(q) - 8;
        if (m_cnt == 0 || bal == 0) begin
            o = {~q8, q8, (q8 ? q : ~q)};
            m_cnt += q8 ? bal : -bal;
        end else if ((m_cnt > 0 && bal > 0) || (m_cnt < 0 && bal < 0)) begin
            o = {1'b1, q8, ~q};
            m_cnt += 2 * int'(q8) - bal;
        end else begin
            o = {1'b0, q8, q};
            m_cnt += bal - 2 * int'(!q8);
        end
        return o;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] c);
        logic [7:0] d;
        logic [7:0] o;
        d = c[9] ? ~c[7:0] : c[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++)
            o[i] = c[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return o;
    endfunction

    task automatic resolve_front();
        slot_t s;
        exp_t  e;
        bit    g;
        s = slot_q.pop_front();
        g = 1'b0;
`ifdef TMDS_VIDEO_GUARD_EN
        g = !s.de && (slot_q[0].de || slot_q[1].de);
`endif
        if (s.de) begin
            e.exp   = model_video(s.din);
            e.video = 1'b1;
        end else begin
            m_cnt   = 0;
            e.exp   = g ? GCH : ctrl_tok(s.ctrl);
            e.video = 1'b0;
        end
        e.din = s.din;
        e.hk  = s.hk;
        e.kv  = s.kv;
        exp_q.push_back(e);
    endtask

    task automatic push_slot(input logic d_e, input logic [1:0] c, input logic [7:0] d,
                             input bit hk, input logic [9:0] kv);
        slot_t s;
        s.de = d_e; s.ctrl = c; s.din = d; s.hk = hk; s.kv = kv;
        slot_q.push_back(s);
        while (slot_q.size() > GL) resolve_front();
    endtask

    task automatic drive(input logic d_e, input logic [1:0] c, input logic [7:0] d,
                         input bit hk, input logic [9:0] kv);
        @(negedge clk);
        de = d_e; ctrl = c; din = d;
        push_slot(d_e, c, d, hk, kv);
    endtask

    // Hold reset for n cycles with random inputs, then release; the pipeline
    // slots emptied by reset are modelled as control 00 slots.
    task automatic reset_pulse(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        slot_q.delete();
        repeat (n) begin
            de = 1'($urandom); ctrl = 2'($urandom); din = 8'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b1;
        m_cnt = 0;
        for (int k = 0; k < LAT - 1; k++) push_slot(1'b0, 2'b00, 8'd0, 1'b0, 10'd0);
        de = 1'b0; ctrl = 2'($urandom); din = 8'($urandom);
        push_slot(de, ctrl, din, 1'b0, 10'd0);
    endtask

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, want, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            check("reset_value", dout, 10'h354);
        end else if (active) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty actual=%h required=queued t=%0t", dout, $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.hk) check("directed", dout, mon_e.kv);
                check("model", dout, mon_e.exp);
                if (mon_e.video) check("decode", {2'b00, decode(dout)}, {2'b00, mon_e.din});
            end
        end
    end

    initial begin
        logic [9:0] gk;
        gk = GEN ? GCH : 10'h354;

        reset_pulse(4);

        drive(1'b0, 2'b00, 8'h5A, 1'b1, 10'h354);
        drive(1'b0, 2'b01, 8'hA5, 1'b1, 10'h0AB);
        drive(1'b0, 2'b10, 8'h3C, 1'b1, 10'h154);
        drive(1'b0, 2'b11, 8'hC3, 1'b1, 10'h2AB);
        drive(1'b0, 2'b00, 8'h00, 1'b0, 10'd0);
        drive(1'b0, 2'b00, 8'h00, 1'b0, 10'd0);

        drive(1'b1, 2'b00, 8'h00, 1'b1, 10'h100);
        drive(1'b1, 2'b00, 8'h00, 1'b1, 10'h3FF);
        drive(1'b1, 2'b00, 8'h00, 1'b1, 10'h100);

        repeat (3) drive(1'b0, 2'b00, 8'h00, 1'b0, 10'd0);
        drive(1'b1, 2'b00, 8'hFF, 1'b1, 10'h200);
        drive(1'b0, 2'b00, 8'h00, 1'b1, gk);
        drive(1'b1, 2'b00, 8'hFF, 1'b1, 10'h200);

        for (int k = 0; k < 10; k++)
            drive(1'b0, 2'b00, 8'h00, 1'b1, (k >= 8) ? gk : 10'h354);
        drive(1'b1, 2'b00, 8'($urandom), 1'b0, 10'd0);
        drive(1'b1, 2'b00, 8'($urandom), 1'b0, 10'd0);
        drive(1'b0, 2'b00, 8'h00, 1'b1, gk);
        drive(1'b1, 2'b00, 8'($urandom), 1'b0, 10'd0);
        drive(1'b0, 2'b00, 8'h00, 1'b0, 10'd0);

        begin
            logic r_de;
            r_de = 1'b0;
            for (int i = 0; i < 10000; i++) begin
                if (i == 6000) begin
                    reset_pulse(3);
                    r_de = 1'b0;
                end else begin
                    if (i >= 5990 && i < 6000) r_de = 1'b1;
                    else if (i < 2000) r_de = 1'($urandom);
                    else if ($urandom_range(0, 5) == 0) r_de = ~r_de;
                    drive(r_de, 2'($urandom), 8'($urandom), 1'b0, 10'd0);
                end
            end
        end

        repeat (4) drive(1'b0, 2'b00, 8'h00, 1'b0, 10'd0);

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        active = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
